// File: rtl/btn_pulse_pkg.sv
// Shared constants for the push-button pulse front end: FSM states, direction encoding, defaults.
package btn_pulse_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_LOCK   = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int unsigned DEF_DEB_CYCLES = 500000;
  localparam int unsigned DEF_REP_DELAY  = 50000000;
  localparam int unsigned DEF_REP_PERIOD = 10000000;
  localparam int unsigned DEF_PULSE_W    = 4;
  localparam int unsigned DEF_CNT_W      = 26;

endpackage

// File: rtl/btn_pulse_gen_f_debounce.sv
// Two-flop synchronizer plus stability-timer debouncer for one raw push-button.
module debounce_f
  import btn_pulse_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_f,
  input  logic raw,
  output logic lvl
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Level only moves after DEB_CYCLES consecutive samples disagreeing with it
  always_ff @(posedge clk or posedge reset_f) begin
    if (reset_f) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      lvl   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        lvl <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_pulse_gen_f.sv
// Up/down button front end: debounced levels, shared press/repeat FSM, mutually exclusive output pulses.
module btn_pulse_gen_f
  import btn_pulse_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned REP_DELAY  = DEF_REP_DELAY,
  parameter int unsigned REP_PERIOD = DEF_REP_PERIOD,
  parameter int unsigned PULSE_W    = DEF_PULSE_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_f,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  input  logic rep_en,
  output logic up_f,
  output logic down_f,
  output logic up_lvl,
  output logic down_lvl
);

  // Pulse counter spans the high phase plus an equal low guard phase
  localparam int unsigned       PCNT_W      = $clog2(2 * PULSE_W + 1);
  localparam logic [PCNT_W-1:0] PCNT_LOAD   = PCNT_W'(2 * PULSE_W);
  localparam logic [PCNT_W-1:0] PCNT_HIGH   = PCNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0]  DELAY_LAST  = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0]  PERIOD_LAST = CNT_W'(REP_PERIOD - 1);

  logic [1:0]        state, state_nxt;
  logic              dir, dir_nxt;
  logic [CNT_W-1:0]  timer, timer_nxt;
  logic [PCNT_W-1:0] pcnt, pcnt_nxt;
  logic              fire;
  logic              dir_lvl, oth_lvl;
  logic [CNT_W-1:0]  timer_tgt;
  logic              up_nxt, down_nxt;

  debounce_f #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_up (
    .clk     (clk),
    .reset_f (reset_f),
    .raw     (btn_up_raw),
    .lvl     (up_lvl)
  );

  debounce_f #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_down (
    .clk     (clk),
    .reset_f (reset_f),
    .raw     (btn_down_raw),
    .lvl     (down_lvl)
  );

  assign dir_lvl   = (dir == DIR_UP) ? up_lvl : down_lvl;
  assign oth_lvl   = (dir == DIR_UP) ? down_lvl : up_lvl;
  assign timer_tgt = (state == ST_FIRST) ? DELAY_LAST : PERIOD_LAST;

  always_ff @(posedge clk or posedge reset_f) begin
    if (reset_f) begin
      state  <= ST_IDLE;
      dir    <= DIR_UP;
      timer  <= '0;
      pcnt   <= '0;
      up_f   <= 1'b0;
      down_f <= 1'b0;
    end else begin
      state  <= state_nxt;
      dir    <= dir_nxt;
      timer  <= timer_nxt;
      pcnt   <= pcnt_nxt;
      up_f   <= up_nxt;
      down_f <= down_nxt;
    end
  end

  // Release wins over lock and repeat; new presses wait for the guard phase to expire
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    timer_nxt = timer;
    fire      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (up_lvl && down_lvl) begin
          state_nxt = ST_LOCK;
        end else if ((up_lvl || down_lvl) && (pcnt == '0)) begin
          fire      = 1'b1;
          dir_nxt   = up_lvl ? DIR_UP : DIR_DOWN;
          timer_nxt = '0;
          state_nxt = ST_FIRST;
        end
      end
      ST_FIRST, ST_REPEAT: begin
        if (!dir_lvl) begin
          state_nxt = ST_IDLE;
        end else if (oth_lvl) begin
          state_nxt = ST_LOCK;
        end else if (rep_en) begin
          if (timer == timer_tgt) begin
            fire      = 1'b1;
            timer_nxt = '0;
            state_nxt = ST_REPEAT;
          end else begin
            timer_nxt = timer + CNT_W'(1);
          end
        end
      end
      ST_LOCK: begin
        if (!up_lvl && !down_lvl) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    pcnt_nxt = '0;
    if (fire)              pcnt_nxt = PCNT_LOAD;
    else if (pcnt != '0)   pcnt_nxt = pcnt - PCNT_W'(1);
    up_nxt   = (pcnt_nxt > PCNT_HIGH) && (dir_nxt == DIR_UP);
    down_nxt = (pcnt_nxt > PCNT_HIGH) && (dir_nxt == DIR_DOWN);
  end

endmodule

// File: tb/tb_btn_pulse_gen_f.sv
// Scoreboard bench for btn_pulse_gen_f: episode stimulus, cycle-level reference model, decoupled monitor.
module tb_btn_pulse_gen_f;

  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 8;
  localparam int PW   = 2;
  localparam int MAXC = 256;

  logic clk = 1'b0;
  logic reset_f = 1'b1;
  logic btn_up_raw = 1'b0;
  logic btn_down_raw = 1'b0;
  logic rep_en = 1'b0;
  logic up_f, down_f, up_lvl, down_lvl;

  always #5 clk = ~clk;

  btn_pulse_gen_f #(
    .DEB_CYCLES (DEB),
    .REP_DELAY  (RDLY),
    .REP_PERIOD (RPER),
    .PULSE_W    (PW),
    .CNT_W      (8)
  ) dut (
    .clk          (clk),
    .reset_f      (reset_f),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .rep_en       (rep_en),
    .up_f         (up_f),
    .down_f       (down_f),
    .up_lvl       (up_lvl),
    .down_lvl     (down_lvl)
  );

  typedef struct {
    bit dn;
    int cyc;
  } pulse_t;

  int     checks = 0;
  int     failures = 0;
  bit     st_up [MAXC];
  bit     st_dn [MAXC];
  bit     st_en [MAXC];
  bit     m_lvl_up [MAXC];
  bit     m_lvl_dn [MAXC];
  pulse_t exp_q [$];
  int     cyc;
  bit     ep_active = 1'b0;
  int     ep_len = 0;

  // Edge count since the last reset release: edge n is the n-th rising edge
  always @(posedge clk or posedge reset_f) begin
    if (reset_f) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic bit raw_at(bit dn, int i);
    if (i < 1) return 1'b0;
    return dn ? st_dn[i] : st_up[i];
  endfunction

  // True when the synchronized history for samples lo..hi is all v
  function automatic bit window_all(bit dn, int lo, int hi, bit v);
    for (int i = lo; i <= hi; i++)
      if (raw_at(dn, i) != v) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: levels move after DEB identical samples (2-edge sync delay);
  // a press pulses at once, then again every RDLY / RPER enabled cycles while held alone.
  task automatic build_model(input int n);
    int mode;    // 0 waiting, 1 one button owns, 2 locked out
    bit own_dn;
    int cnt;
    int need;
    int last;
    bit lu, ld, own, oth;
    mode = 0; own_dn = 1'b0; cnt = 0; need = RDLY; last = -1000;
    m_lvl_up[0] = 1'b0;
    m_lvl_dn[0] = 1'b0;
    for (int e = 1; e <= n; e++) begin
      lu = m_lvl_up[e-1];
      ld = m_lvl_dn[e-1];
      case (mode)
        0: begin
          if (lu && ld) mode = 2;
          else if ((lu || ld) && (e - last > 2 * PW)) begin
            own_dn = !lu;
            exp_q.push_back('{dn: own_dn, cyc: e});
            last = e; cnt = 0; need = RDLY; mode = 1;
          end
        end
        1: begin
          own = own_dn ? ld : lu;
          oth = own_dn ? lu : ld;
          if (!own) mode = 0;
          else if (oth) mode = 2;
          else if (st_en[e]) begin
            cnt++;
            if (cnt == need) begin
              exp_q.push_back('{dn: own_dn, cyc: e});
              last = e; cnt = 0; need = RPER;
            end
          end
        end
        default: if (!lu && !ld) mode = 0;
      endcase
      m_lvl_up[e] = window_all(1'b0, e - 1 - DEB, e - 2, !m_lvl_up[e-1]) ? !m_lvl_up[e-1] : m_lvl_up[e-1];
      m_lvl_dn[e] = window_all(1'b1, e - 1 - DEB, e - 2, !m_lvl_dn[e-1]) ? !m_lvl_dn[e-1] : m_lvl_dn[e-1];
    end
  endtask

  // Monitor: sampled on the falling edge, pops the scoreboard at each pulse start
  initial begin
    bit     sig [2];
    int     run [2];
    pulse_t p;
    run[0] = 0; run[1] = 0;
    forever begin
      @(negedge clk or posedge reset_f);
      if (reset_f) begin
        run[0] = 0; run[1] = 0;
      end else begin
        sig[0] = up_f;
        sig[1] = down_f;
        check("exclusive", 32'(up_f & down_f), 0);
        if (ep_active && cyc >= 1 && cyc <= ep_len) begin
          check("up_lvl", 32'(up_lvl), 32'(m_lvl_up[cyc]));
          check("down_lvl", 32'(down_lvl), 32'(m_lvl_dn[cyc]));
        end
        for (int d = 0; d < 2; d++) begin
          if (sig[d] && run[d] == 0) begin
            if (exp_q.size() == 0) begin
              check(d ? "unexpected_down_f" : "unexpected_up_f", 32'(sig[d]), 0);
            end else begin
              p = exp_q.pop_front();
              check("pulse_dir", 32'(d), 32'(p.dn));
              check("pulse_edge", 32'(cyc), 32'(p.cyc));
            end
          end
          if (sig[d]) run[d]++;
          else if (run[d] > 0) begin
            check("pulse_width", 32'(run[d]), 32'(PW));
            run[d] = 0;
          end
        end
      end
    end
  end

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      st_up[i] = 1'b0; st_dn[i] = 1'b0; st_en[i] = 1'b0;
    end
  endtask

  task automatic run_episode(input int n);
    ep_active = 1'b0;
    reset_f = 1'b1;
    btn_up_raw = 1'b0; btn_down_raw = 1'b0; rep_en = 1'b0;
    #1;
    check("rst_up_f", 32'(up_f), 0);
    check("rst_down_f", 32'(down_f), 0);
    check("rst_up_lvl", 32'(up_lvl), 0);
    check("rst_down_lvl", 32'(down_lvl), 0);
    exp_q.delete();
    build_model(n);
    @(negedge clk);
    ep_len = n;
    ep_active = 1'b1;
    btn_up_raw = st_up[1]; btn_down_raw = st_dn[1]; rep_en = st_en[1];
    reset_f = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k < n) begin
        btn_up_raw = st_up[k+1]; btn_down_raw = st_dn[k+1]; rep_en = st_en[k+1];
      end
    end
    @(negedge clk);
    #1;
    check("pulses_outstanding", 32'(exp_q.size()), 0);
  endtask

  task automatic random_segments(input bit dn, input int len);
    int i = 1;
    while (i <= len) begin
      int seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 30));
      bit v = 1'($urandom_range(0, 1));
      for (int j = 0; j < seg && i <= len; j++) begin
        if (dn) st_dn[i] = v; else st_up[i] = v;
        i++;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // Clean press, no repeat
    clear_stim();
    for (int i = 1; i <= 10; i++) st_up[i] = 1'b1;
    run_episode(40);

    // Bouncing down button settles high
    clear_stim();
    for (int i = 1; i <= 12; i++) st_dn[i] = (((i - 1) / 2) % 2) == 0;
    for (int i = 13; i <= 30; i++) st_dn[i] = 1'b1;
    run_episode(60);

    // Long hold with auto-repeat
    clear_stim();
    for (int i = 1; i <= 60; i++) st_up[i] = 1'b1;
    for (int i = 1; i < MAXC; i++) st_en[i] = 1'b1;
    run_episode(100);

    // Simultaneous press locks out, then a single up press
    clear_stim();
    for (int i = 1; i <= 30; i++) begin st_up[i] = 1'b1; st_dn[i] = 1'b1; end
    for (int i = 46; i <= 55; i++) st_up[i] = 1'b1;
    run_episode(80);

    // Down pressed while up is held
    clear_stim();
    for (int i = 1; i <= 50; i++) st_up[i] = 1'b1;
    for (int i = 10; i <= 40; i++) st_dn[i] = 1'b1;
    for (int i = 1; i < MAXC; i++) st_en[i] = 1'b1;
    run_episode(90);

    // Reset lands inside an up pulse; button stays held across reset
    clear_stim();
    for (int i = 1; i < MAXC; i++) st_up[i] = 1'b1;
    run_episode(8);
    check("pulse_before_reset", 32'(up_f), 1);
    run_episode(40);

    // Randomized episodes with a quiet tail so everything drains
    for (int r = 0; r < 10; r++) begin
      clear_stim();
      random_segments(1'b0, 130);
      random_segments(1'b1, 130);
      begin
        int i = 1;
        while (i <= 130) begin
          int seg = int'($urandom_range(10, 60));
          bit v = ($urandom_range(0, 3) != 0);
          for (int j = 0; j < seg && i <= 130; j++) begin
            st_en[i] = v;
            i++;
          end
        end
      end
      run_episode(160);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
